lmac_crc32_engine: RTL and testbench

- Parametrised, frame-aware CRC-32 engine (IEEE 802.3 polynomial 0x04C11DB7) for the LMAC TX and RX datapaths.
- Accepts DATA_W-bit beats with start-of-packet, end-of-packet and partial-last-beat byte count.
- Owns the running CRC state and reports a finished FCS (TX, generate mode) or a pass/fail check (RX, check mode) one cycle after the last beat.
- Supersedes fixed-width per-width CRC slices.

---
 rtl/lmac_crc_pkg.sv | 37 +++
 rtl/lmac_crc32_byte_step.sv | 12 +
 rtl/lmac_crc32_engine.sv | 148 ++++++++++++++
 tb/tb_lmac_crc32_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmac_crc_pkg.sv
// rtl/lmac_crc_pkg.sv - shared CRC-32 constants, types and byte-update helpers
package lmac_crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_SEED    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef logic [31:0] crc32_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // One byte through the register, bit 0 of the byte first on the wire.
  // The register keeps the polynomial's x^31 term in bit 31 (non-reflected form).
  function automatic crc32_t crc32_byte(crc32_t c, byte d);
    crc32_t r;
    logic   fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    return r;
  endfunction

  // Bit reversal: maps the register onto wire order (first wire bit in bit 0).
  function automatic crc32_t crc32_rev(crc32_t c);
    crc32_t r;
    for (int i = 0; i < 32; i++) begin
      r[i] = c[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lmac_crc32_byte_step.sv
// rtl/lmac_crc32_byte_step.sv - combinational single-byte CRC-32 update stage
module lmac_crc32_byte_step
  import lmac_crc_pkg::*;
(
  input  crc32_t     crc_in,
  input  logic [7:0] data,
  output crc32_t     crc_out
);

  assign crc_out = crc32_byte(crc_in, data);

endmodule

// File: rtl/lmac_crc32_engine.sv
// rtl/lmac_crc32_engine.sv - frame-aware CRC-32 generate/check engine; optional stats via LMAC_CRC_STATS_EN
module lmac_crc32_engine
  import lmac_crc_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int LANES  = DATA_W / 8,
  localparam int MOD_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [MOD_W-1:0]  in_mod,
  input  logic              in_abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  output logic              out_valid,
  output logic [31:0]       out_fcs,
  output logic              out_crc_ok,
  output logic              busy
`ifdef LMAC_CRC_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_err_cnt,
  output logic [15:0]       stat_frm_cnt,
  output logic              stat_restart
`endif
);

  state_t state;
  crc32_t crc_q;
  logic   mode_q;

  crc32_t chain_in;
  crc32_t taps [LANES];
  crc32_t crc_sel;
  logic   accept;
  logic   restart_evt;
  logic   result_evt;
  logic   eff_mode;
  logic   ok_next;

  // A sop beat always starts from the seed, so a restart needs no extra clear cycle.
  assign chain_in = in_sop ? CRC32_SEED : crc_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    if (g == 0) begin : g_first
      lmac_crc32_byte_step u_step (
        .crc_in  (chain_in),
        .data    (in_data[7:0]),
        .crc_out (taps[0])
      );
    end else begin : g_next
      lmac_crc32_byte_step u_step (
        .crc_in  (taps[g-1]),
        .data    (in_data[8*g +: 8]),
        .crc_out (taps[g])
      );
    end
  end

  // Pick the chain tap after in_mod bytes on a partial eop beat, else after all lanes.
  always_comb begin
    crc_sel = taps[LANES-1];
    if (in_eop && (in_mod != '0)) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_mod == MOD_W'(i + 1)) begin
          crc_sel = taps[i];
        end
      end
    end
  end

  // Beat classification; abort outranks any beat on the same cycle.
  always_comb begin
    accept      = in_valid && !in_abort && (in_sop || (state == ST_ACTIVE));
    restart_evt = in_valid && !in_abort && in_sop && (state == ST_ACTIVE);
    result_evt  = accept && in_eop;
    eff_mode    = in_sop ? mode : mode_q;
    ok_next     = (crc_sel == CRC32_RESIDUE);
  end

  // Frame FSM, running register and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      crc_q      <= CRC32_SEED;
      mode_q     <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_fcs    <= 32'h0;
      out_crc_ok <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_abort) begin
        state <= ST_IDLE;
        crc_q <= CRC32_SEED;
        busy  <= 1'b0;
      end else if (accept) begin
        if (in_sop) begin
          mode_q <= mode;
        end
        if (in_eop) begin
          state      <= ST_IDLE;
          crc_q      <= CRC32_SEED;
          busy       <= 1'b0;
          out_valid  <= 1'b1;
          out_fcs    <= eff_mode ? crc_sel : ~crc32_rev(crc_sel);
          out_crc_ok <= eff_mode ? ok_next : 1'b1;
        end else begin
          state <= ST_ACTIVE;
          crc_q <= crc_sel;
          busy  <= 1'b1;
        end
      end
    end
  end

`ifdef LMAC_CRC_STATS_EN
  // Statistics: saturating error count, wrapping frame count, sticky restart; clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_err_cnt <= 16'h0;
      stat_frm_cnt <= 16'h0;
      stat_restart <= 1'b0;
    end else if (stat_clr) begin
      stat_err_cnt <= 16'h0;
      stat_frm_cnt <= 16'h0;
      stat_restart <= 1'b0;
    end else begin
      if (restart_evt) begin
        stat_restart <= 1'b1;
      end
      if (result_evt) begin
        stat_frm_cnt <= stat_frm_cnt + 16'd1;
        if (eff_mode && !ok_next && (stat_err_cnt != 16'hFFFF)) begin
          stat_err_cnt <= stat_err_cnt + 16'd1;
        end
      end
    end
  end
`else
  logic unused_evt;
  assign unused_evt = restart_evt & result_evt;
`endif

endmodule

// File: tb/tb_lmac_crc32_engine.sv
// tb/tb_lmac_crc32_engine.sv - randomized self-checking bench for lmac_crc32_engine
module tb_lmac_crc32_engine;

  localparam int DATA_W = 64;
  localparam int LANES  = 8;
  localparam int MOD_W  = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          due;
    logic [31:0] fcs;
    logic        ok;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic [MOD_W-1:0]  in_mod;
  logic              in_abort;
  logic [DATA_W-1:0] in_data;
  logic              mode;
  logic              out_valid;
  logic [31:0]       out_fcs;
  logic              out_crc_ok;
  logic              busy;
`ifdef LMAC_CRC_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat_err_cnt;
  logic [15:0]       stat_frm_cnt;
  logic              stat_restart;
`endif

  lmac_crc32_engine #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_mod     (in_mod),
    .in_abort   (in_abort),
    .in_data    (in_data),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_fcs    (out_fcs),
    .out_crc_ok (out_crc_ok),
    .busy       (busy)
`ifdef LMAC_CRC_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_err_cnt (stat_err_cnt),
    .stat_frm_cnt (stat_frm_cnt),
    .stat_restart (stat_restart)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  bq_t         fb;
  logic        fmode = 1'b0;
  logic        in_frame = 1'b0;
  logic        nb = 1'b0;
  logic        model_busy;
  logic [31:0] last_fcs = 32'h0;
  logic        last_ok = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) model_busy <= 1'b0;
    else      model_busy <= nb;
  end

  // Reference: textbook reflected CRC-32 over a byte list.
  function automatic logic [31:0] ref_crc(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input bq_t q, input logic md);
    exp_t        e;
    logic [31:0] r;
    r     = ref_crc(q);
    e.due = cyc + 1;
    if (md) begin
      e.fcs = rev32(r);
      e.ok  = (r == 32'hDEBB20E3);
    end else begin
      e.fcs = ~r;
      e.ok  = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Apply one beat for one cycle and update the frame-level model.
  task automatic drive(input logic v, input logic s, input logic e, input logic [MOD_W-1:0] m,
                       input logic a, input logic [DATA_W-1:0] d, input logic md);
    int n;
    in_valid = v; in_sop = s; in_eop = e; in_mod = m; in_abort = a; in_data = d; mode = md;
    if (a) begin
      in_frame = 1'b0;
      nb       = 1'b0;
    end else if (v && (s || in_frame)) begin
      n = (e && (m != '0)) ? int'(m) : LANES;
      if (s) begin
        fb.delete();
        fmode = md;
      end
      for (int i = 0; i < n; i++) fb.push_back(d[8*i +: 8]);
      if (e) begin
        push_exp(fb, fmode);
        in_frame = 1'b0;
      end else begin
        in_frame = 1'b1;
      end
      nb = in_frame;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_abort = 1'b0;
    in_sop   = 1'($urandom);
    in_eop   = 1'($urandom);
    in_data  = {$urandom, $urandom};
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom), 1'($urandom), MOD_W'($urandom), 1'b0, {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic send_frame(input bq_t q, input logic md, input int bubble_pct);
    int                nbeats;
    int                rem;
    logic              last;
    logic [MOD_W-1:0]  m;
    logic [DATA_W-1:0] d;
    nbeats = (q.size() + LANES - 1) / LANES;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(99) < bubble_pct) idle();
      rem  = q.size() - b * LANES;
      last = (b == nbeats - 1);
      d    = {$urandom, $urandom};
      for (int i = 0; i < LANES && i < rem; i++) d[8*i +: 8] = q[b*LANES + i];
      m = last ? MOD_W'(rem % LANES) : MOD_W'($urandom);
      drive(1'b1, b == 0, last, m, 1'b0, d, (b == 0) ? md : 1'($urandom));
    end
  endtask

  // Per-cycle compare of result pulse, held result and busy against the model.
  always @(negedge clk) begin
    exp_t e;
    if (rst && chk_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        check1("result_missed", 1'b0, 1'b1);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check1("out_valid", out_valid, 1'b1);
        check("out_fcs", out_fcs, e.fcs);
        check1("out_crc_ok", out_crc_ok, e.ok);
        last_fcs = e.fcs;
        last_ok  = e.ok;
      end else begin
        check1("out_valid_idle", out_valid, 1'b0);
        check("out_fcs_hold", out_fcs, last_fcs);
        check1("out_crc_ok_hold", out_crc_ok, last_ok);
      end
      check1("busy", busy, model_busy);
    end
  end

  initial begin
    bq_t         s9, c13, bad, q;
    logic [31:0] r;
    int          len;
    logic        md;

    rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = '0;
    in_abort = 1'b0; in_data = '0; mode = 1'b0;
`ifdef LMAC_CRC_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_fcs", out_fcs, 32'h0);
    check1("rst_out_crc_ok", out_crc_ok, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst    = 1'b1;
    chk_en = 1'b1;

    s9  = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c13 = {s9, 8'h26, 8'h39, 8'hF4, 8'hCB};
    check("model_pin_fcs", ~ref_crc(s9), 32'hCBF43926);
    check("model_pin_residue", rev32(ref_crc(c13)), 32'hC704DD7B);

    // generate "123456789"
    send_frame(s9, 1'b0, 0);
    repeat (2) idle();
    check("gen_lit", out_fcs, 32'hCBF43926);

    // check mode, good then corrupted bit 0 of byte 3
    send_frame(c13, 1'b1, 0);
    repeat (2) idle();
    check1("chk_good_lit", out_crc_ok, 1'b1);
    check("chk_raw_lit", out_fcs, 32'hC704DD7B);
    bad    = c13;
    bad[3] = bad[3] ^ 8'h01;
    send_frame(bad, 1'b1, 0);
    repeat (2) idle();
    check1("chk_bad_lit", out_crc_ok, 1'b0);

    // single-beat frame with bubbles around it
    repeat (3) idle();
    drive(1'b1, 1'b1, 1'b1, '0, 1'b0, 64'h0706050403020100, 1'b0);
    repeat (3) idle();

    // abort mid-frame (abort beats a valid beat on the same cycle)
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'b0);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b1, {$urandom, $urandom}, 1'b0);
    idle();
    send_frame(s9, 1'b0, 0);
    repeat (2) idle();
    check("abort_then_lit", out_fcs, 32'hCBF43926);

    // sop while active
`ifdef LMAC_CRC_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
`endif
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'b1);
    send_frame(s9, 1'b0, 0);
    repeat (2) idle();
    check("restart_lit", out_fcs, 32'hCBF43926);
`ifdef LMAC_CRC_STATS_EN
    check1("stat_restart", stat_restart, 1'b1);
    check("stat_frm_cnt", 32'(stat_frm_cnt), 32'd1);
`endif

    // asynchronous reset mid-frame
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'b0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    in_frame = 1'b0;
    nb       = 1'b0;
    last_fcs = 32'h0;
    last_ok  = 1'b0;
    #1;
    check1("arst_out_valid", out_valid, 1'b0);
    check("arst_out_fcs", out_fcs, 32'h0);
    check1("arst_out_crc_ok", out_crc_ok, 1'b0);
    check1("arst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(s9, 1'b0, 0);
    repeat (2) idle();
    check("post_rst_lit", out_fcs, 32'hCBF43926);

    // randomized frames with bubbles, aborts, restarts, mid-frame mode toggles
    for (int f = 0; f < 300; f++) begin
      len = $urandom_range(1, 40);
      md  = 1'($urandom);
      q.delete();
      repeat (len) q.push_back(8'($urandom));
      if (md && ($urandom_range(3) != 0)) begin
        r = ~ref_crc(q);
        for (int k = 0; k < 4; k++) q.push_back(r[8*k +: 8]);
        if ($urandom_range(3) == 0) q[$urandom_range(q.size() - 1)] ^= 8'(1 << $urandom_range(7));
      end
      case ($urandom_range(9))
        0: begin
          drive(1'b1, 1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'($urandom));
          if ($urandom_range(1) == 1) idle();
          drive(1'($urandom), 1'($urandom), 1'($urandom), MOD_W'($urandom), 1'b1, {$urandom, $urandom}, 1'($urandom));
        end
        1: drive(1'b1, 1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom}, 1'($urandom));
        default: ;
      endcase
      send_frame(q, md, 20);
      if ($urandom_range(2) == 0) idle();
    end
    repeat (3) idle();

`ifdef LMAC_CRC_STATS_EN
    // error counter saturation
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    repeat (65540) drive(1'b1, 1'b1, 1'b1, '0, 1'b0, 64'h0, 1'b1);
    repeat (2) idle();
    check("stat_err_sat", 32'(stat_err_cnt), 32'h0000FFFF);
    check("stat_frm_wrap", 32'(stat_frm_cnt), 32'd4);
`endif

    chk_en = 1'b0;
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
